// File: rtl/i2c_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_pkg
//  Description : Shared types and constants for the I2C SCL timing generator.
//                - i2c_phase_t : quarter of the SCL bit period (Q0..Q3)
//                - quarter-to-(scl,data_clk) level table and lookup function
//                - SYNC_STAGES : depth of the SCL input synchroniser
//  Revision    : 1.0 - initial release
// ============================================================================
package i2c_pkg;

    typedef enum logic [1:0] {
        Q0 = 2'd0,
        Q1 = 2'd1,
        Q2 = 2'd2,
        Q3 = 2'd3
    } i2c_phase_t;

    localparam int SYNC_STAGES = 2;

    // {scl, data_clk} per quarter, Q3 in the top pair and Q0 in the bottom pair:
    // Q0=(0,0) Q1=(0,1) Q2=(1,1) Q3=(1,0)
    localparam logic [7:0] c_quarter_tbl = {2'b10, 2'b11, 2'b01, 2'b00};

    function automatic logic [1:0] quarter_levels(input i2c_phase_t p);
        logic [2:0] idx;
        idx = {p, 1'b0};
        return c_quarter_tbl[idx +: 2];
    endfunction

endpackage
`default_nettype wire

// File: rtl/sync_2ff.sv
`default_nettype none
// ============================================================================
//  Module      : sync_2ff
//  Description : Multi-flop synchroniser for an asynchronous level input.
//                All stages reset to 1 so an idle (released) bus is seen
//                straight out of reset.
//  Ports       : clk   - system clock
//                rst_n - asynchronous active-low reset
//                i_d   - asynchronous input level
//                o_q   - synchronised level (STAGES cycles latency)
//  Revision    : 1.0 - initial release
// ============================================================================
module sync_2ff
    import i2c_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/i2c_scl_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_scl_timing_gen
//  Description : Four-quarter SCL / data-clock generator for the I2C master.
//                Runtime quarter divider, enable/idle, synchronised clock-
//                stretch detection with sticky timeout, per-quarter tick.
//  Ports       : clk        - system clock
//                rst_n      - asynchronous active-low reset
//                en         - 1 = generate clock, 0 = idle
//                div_i      - quarter length in clk cycles (0 treated as 1)
//                scl_ena    - master drives SCL; enables stretch detection
//                scl_in     - raw SCL pad level (asynchronous)
//                scl_clk    - SCL level to drive (1 = release)
//                data_clk   - SDA update/sample clock
//                phase      - current quarter Q0..Q3
//                qtick      - pulse on first cycle of every quarter
//                stretching - stretch hold active
//                timeout    - sticky stretch-timeout flag
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_scl_timing_gen
    import i2c_pkg::*;
#(
    parameter int CBITS   = 16,
    parameter int TO_BITS = 20,
    parameter int TIMEOUT = 2**20 - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CBITS-1:0] div_i,
    input  logic             scl_ena,
    input  logic             scl_in,
    output logic             scl_clk,
    output logic             data_clk,
    output logic [1:0]       phase,
    output logic             qtick,
    output logic             stretching,
    output logic             timeout
);

    localparam logic [TO_BITS-1:0] c_to_last = TO_BITS'(TIMEOUT - 1);

    i2c_phase_t         r_phase;
    logic [CBITS-1:0]   r_cnt;
    logic [CBITS-1:0]   r_div_l;
    logic [TO_BITS-1:0] r_to_cnt;
    logic               r_en_d;
    logic               r_scl_clk;
    logic               r_data_clk;
    logic               r_qtick;
    logic               r_stretching;
    logic               r_timeout;

    logic               w_scl_s;
    logic [CBITS-1:0]   w_div_eff;
    logic               w_term;
    logic               w_hold;
    logic               w_to_fire;
    logic               w_stall;
    i2c_phase_t         w_next_phase;

    sync_2ff #(
        .STAGES (SYNC_STAGES)
    ) u_scl_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (scl_in),
        .o_q   (w_scl_s)
    );

    assign w_div_eff    = (div_i == '0) ? CBITS'(1) : div_i;
    assign w_term       = (r_cnt == r_div_l - CBITS'(1));
    // A slave holding SCL low at the end of Q2 keeps the high quarter open.
    assign w_hold       = (r_phase == Q2) && w_term && scl_ena && !w_scl_s;
    // Only an ongoing stretch can time out; the last allowed cycle forces release.
    assign w_to_fire    = w_hold && r_stretching && (r_to_cnt == c_to_last);
    assign w_stall      = w_hold && !w_to_fire;
    assign w_next_phase = i2c_phase_t'(r_phase + 2'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase      <= Q0;
            r_cnt        <= '0;
            r_div_l      <= CBITS'(1);
            r_to_cnt     <= '0;
            r_en_d       <= 1'b0;
            r_scl_clk    <= 1'b1;
            r_data_clk   <= 1'b0;
            r_qtick      <= 1'b0;
            r_stretching <= 1'b0;
            r_timeout    <= 1'b0;
        end else if (!en) begin
            // Idle: released bus, everything cleared including the sticky timeout.
            r_phase      <= Q0;
            r_cnt        <= '0;
            r_to_cnt     <= '0;
            r_en_d       <= 1'b0;
            r_scl_clk    <= 1'b1;
            r_data_clk   <= 1'b0;
            r_qtick      <= 1'b0;
            r_stretching <= 1'b0;
            r_timeout    <= 1'b0;
        end else if (!r_en_d) begin
            // First enabled cycle: enter Q0 with a tick and latch the divider.
            r_phase      <= Q0;
            r_cnt        <= '0;
            r_div_l      <= w_div_eff;
            r_to_cnt     <= '0;
            r_en_d       <= 1'b1;
            {r_scl_clk, r_data_clk} <= quarter_levels(Q0);
            r_qtick      <= 1'b1;
            r_stretching <= 1'b0;
        end else begin
            r_stretching <= w_stall;
            // Cleared whenever the hold ends, so it never passes c_to_last.
            r_to_cnt     <= (r_stretching && w_stall) ? r_to_cnt + TO_BITS'(1) : '0;
            if (w_to_fire) begin
                r_timeout <= 1'b1;
            end
            if (w_term && !w_stall) begin
                r_cnt   <= '0;
                r_phase <= w_next_phase;
                {r_scl_clk, r_data_clk} <= quarter_levels(w_next_phase);
                r_qtick <= 1'b1;
                // Divider only changes on a bit boundary.
                if (r_phase == Q3) begin
                    r_div_l <= w_div_eff;
                end
            end else begin
                r_qtick <= 1'b0;
                if (!w_stall) begin
                    r_cnt <= r_cnt + CBITS'(1);
                end
            end
        end
    end

    assign scl_clk    = r_scl_clk;
    assign data_clk   = r_data_clk;
    assign phase      = r_phase;
    assign qtick      = r_qtick;
    assign stretching = r_stretching;
    assign timeout    = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_i2c_scl_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_scl_timing_gen
//  Description : Directed self-checking bench for i2c_scl_timing_gen
//                (TIMEOUT = 16). Inputs change 1 ns after the rising edge,
//                outputs are sampled at the same point.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_scl_timing_gen;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en = 1'b0;
    logic [15:0] div_i = 16'd2;
    logic        scl_ena = 1'b1;
    logic        scl_in = 1'b1;
    logic        scl_clk;
    logic        data_clk;
    logic [1:0]  phase;
    logic        qtick;
    logic        stretching;
    logic        timeout;

    int checks = 0;
    int passes = 0;

    i2c_scl_timing_gen #(
        .CBITS   (16),
        .TO_BITS (20),
        .TIMEOUT (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .div_i      (div_i),
        .scl_ena    (scl_ena),
        .scl_in     (scl_in),
        .scl_clk    (scl_clk),
        .data_clk   (data_clk),
        .phase      (phase),
        .qtick      (qtick),
        .stretching (stretching),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic go_idle();
        en     = 1'b0;
        scl_in = 1'b1;
        repeat (4) step();
    endtask

    // {scl_clk, data_clk, phase, qtick, stretching, timeout}
    task automatic test_reset();
        logic [6:0] obs;
        rst_n = 1'b0;
        #12;
        obs = {scl_clk, data_clk, phase, qtick, stretching, timeout};
        checks++;
        if (obs !== 7'b10_00_000) $display("FAIL reset_state got=%b exp=%b", obs, 7'b10_00_000);
        else passes++;
        @(negedge clk);
        rst_n = 1'b1;
        step();
        obs = {scl_clk, data_clk, phase, qtick, stretching, timeout};
        checks++;
        if (obs !== 7'b10_00_000) $display("FAIL idle_after_reset got=%b exp=%b", obs, 7'b10_00_000);
        else passes++;
    endtask

    task automatic test_basic();
        logic [0:7] s_tbl;
        logic [0:7] d_tbl;
        logic [0:7] q_tbl;
        logic [4:0] obs;
        logic [4:0] exp_v;
        int k;
        s_tbl  = 8'b0000_1111;
        d_tbl  = 8'b0011_1100;
        q_tbl  = 8'b1010_1010;
        div_i  = 16'd2;
        scl_in = 1'b1;
        en     = 1'b1;
        for (int n = 1; n <= 16; n++) begin
            step();
            k     = (n - 1) % 8;
            exp_v = {s_tbl[k], d_tbl[k], q_tbl[k], 2'(k / 2)};
            obs   = {scl_clk, data_clk, qtick, phase};
            checks++;
            if (obs !== exp_v) $display("FAIL basic_div2 cyc=%0d got=%b exp=%b", n, obs, exp_v);
            else passes++;
        end
        go_idle();
    endtask

    task automatic test_stretch();
        logic [1:0] ep;
        logic [6:0] obs;
        logic [6:0] exp_v;
        div_i  = 16'd4;
        scl_in = 1'b1;
        en     = 1'b1;
        for (int n = 1; n <= 28; n++) begin
            step();
            if (n <= 4)       ep = 2'd0;
            else if (n <= 8)  ep = 2'd1;
            else if (n <= 23) ep = 2'd2;
            else if (n <= 27) ep = 2'd3;
            else              ep = 2'd0;
            exp_v = {ep >= 2'd2, (ep == 2'd1) || (ep == 2'd2), ep,
                     (n == 1) || (n == 5) || (n == 9) || (n == 24) || (n == 28),
                     (n >= 13) && (n <= 23), 1'b0};
            obs   = {scl_clk, data_clk, phase, qtick, stretching, timeout};
            checks++;
            if (obs !== exp_v) $display("FAIL stretch cyc=%0d got=%b exp=%b", n, obs, exp_v);
            else passes++;
            if (n == 9)  scl_in = 1'b0;
            if (n == 21) scl_in = 1'b1;
        end
        go_idle();
    endtask

    task automatic test_timeout();
        logic [1:0] ep;
        logic [6:0] obs;
        logic [6:0] exp_v;
        div_i  = 16'd2;
        scl_in = 1'b0;
        repeat (3) step();
        en = 1'b1;
        for (int n = 1; n <= 50; n++) begin
            step();
            if (n <= 2)       ep = 2'd0;
            else if (n <= 4)  ep = 2'd1;
            else if (n <= 22) ep = 2'd2;
            else if (n <= 24) ep = 2'd3;
            else if (n <= 26) ep = 2'd0;
            else if (n <= 28) ep = 2'd1;
            else if (n <= 46) ep = 2'd2;
            else if (n <= 48) ep = 2'd3;
            else              ep = 2'd0;
            exp_v = {ep >= 2'd2, (ep == 2'd1) || (ep == 2'd2), ep,
                     (n == 1) || (n == 3) || (n == 5) || (n == 23) || (n == 25) ||
                     (n == 27) || (n == 29) || (n == 47) || (n == 49),
                     ((n >= 7) && (n <= 22)) || ((n >= 31) && (n <= 46)),
                     n >= 23};
            obs   = {scl_clk, data_clk, phase, qtick, stretching, timeout};
            checks++;
            if (obs !== exp_v) $display("FAIL timeout cyc=%0d got=%b exp=%b", n, obs, exp_v);
            else passes++;
        end
        en     = 1'b0;
        scl_in = 1'b1;
        step();
        obs = {scl_clk, data_clk, phase, qtick, stretching, timeout};
        checks++;
        if (obs !== 7'b10_00_000) $display("FAIL timeout_clear_on_idle got=%b exp=%b", obs, 7'b10_00_000);
        else passes++;
        go_idle();
    endtask

    task automatic test_div_change();
        logic [1:0] ep;
        logic       eq;
        logic [2:0] obs;
        logic [2:0] exp_v;
        div_i  = 16'd2;
        scl_in = 1'b1;
        en     = 1'b1;
        for (int n = 1; n <= 22; n++) begin
            step();
            if (n <= 8) begin
                ep = 2'((n - 1) / 2);
                eq = (n % 2) == 1;
            end else if (n <= 20) begin
                ep = 2'((n - 9) / 3);
                eq = ((n - 9) % 3) == 0;
            end else begin
                ep = 2'd0;
                eq = (n == 21);
            end
            exp_v = {ep, eq};
            obs   = {phase, qtick};
            checks++;
            if (obs !== exp_v) $display("FAIL div_change cyc=%0d got=%b exp=%b", n, obs, exp_v);
            else passes++;
            if (n == 3) div_i = 16'd3;
        end
        go_idle();
    endtask

    task automatic test_async_reset();
        logic [6:0] obs;
        logic [6:0] exp_v;
        div_i  = 16'd4;
        scl_in = 1'b1;
        en     = 1'b1;
        repeat (10) step();
        obs = {scl_clk, data_clk, phase, qtick, stretching, timeout};
        checks++;
        if (obs !== 7'b11_10_000) $display("FAIL pre_reset_q2 got=%b exp=%b", obs, 7'b11_10_000);
        else passes++;
        #2;
        rst_n = 1'b0;
        #1;
        obs = {scl_clk, data_clk, phase, qtick, stretching, timeout};
        checks++;
        if (obs !== 7'b10_00_000) $display("FAIL async_reset_immediate got=%b exp=%b", obs, 7'b10_00_000);
        else passes++;
        step();
        #2;
        rst_n = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            step();
            exp_v = (n <= 4) ? {2'b00, 2'd0, n == 1, 2'b00} : {2'b01, 2'd1, n == 5, 2'b00};
            obs   = {scl_clk, data_clk, phase, qtick, stretching, timeout};
            checks++;
            if (obs !== exp_v) $display("FAIL restart_after_reset cyc=%0d got=%b exp=%b", n, obs, exp_v);
            else passes++;
        end
        go_idle();
    endtask

    task automatic test_div0_en_drop();
        logic [1:0] ep;
        logic [6:0] obs;
        logic [6:0] exp_v;
        div_i  = 16'd0;
        scl_in = 1'b1;
        en     = 1'b1;
        for (int n = 1; n <= 6; n++) begin
            step();
            ep    = 2'((n - 1) % 4);
            exp_v = {ep >= 2'd2, (ep == 2'd1) || (ep == 2'd2), ep, 3'b100};
            obs   = {scl_clk, data_clk, phase, qtick, stretching, timeout};
            checks++;
            if (obs !== exp_v) $display("FAIL div0 cyc=%0d got=%b exp=%b", n, obs, exp_v);
            else passes++;
        end
        en = 1'b0;
        for (int n = 1; n <= 2; n++) begin
            step();
            obs = {scl_clk, data_clk, phase, qtick, stretching, timeout};
            checks++;
            if (obs !== 7'b10_00_000) $display("FAIL en_drop_idle cyc=%0d got=%b exp=%b", n, obs, 7'b10_00_000);
            else passes++;
        end
        en = 1'b1;
        step();
        obs = {scl_clk, data_clk, phase, qtick, stretching, timeout};
        checks++;
        if (obs !== 7'b00_00_100) $display("FAIL reenable_q0 got=%b exp=%b", obs, 7'b00_00_100);
        else passes++;
        step();
        obs = {scl_clk, data_clk, phase, qtick, stretching, timeout};
        checks++;
        if (obs !== 7'b01_01_100) $display("FAIL reenable_q1 got=%b exp=%b", obs, 7'b01_01_100);
        else passes++;
        go_idle();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stretch();
        test_timeout();
        test_div_change();
        test_async_reset();
        test_div0_en_drop();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
